// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit controller: frame FSM, LSB-first serializer, parity generator
// and bit-period timer. All configuration is captured when a frame is accepted.
//
// state  | meaning
// IDLE   | line high, waiting for Data_valid
// START  | start bit (low) for one bit period
// DATA   | payload bit idx, LSB first
// PARITY | parity bit (only when par_en was latched)
// STOP   | one or two stop-bit periods, tx_done on the final clock
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state, nxt_state;
  logic [IW-1:0]         idx, nxt_idx;
  logic [DIV_WIDTH-1:0]  cnt, nxt_cnt;
  logic                  stop_idx, nxt_stop;
  logic                  accept;
  logic                  nxt_tx, nxt_done;
  logic                  bit_end;

  logic [DATA_WIDTH-1:0] data_l;
  logic                  par_en_l, par_typ_l, stop2_l;
  logic [DIV_WIDTH-1:0]  div_l;

  assign bit_end = (cnt == div_l);

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = bit_end ? '0 : cnt + DIV_WIDTH'(1);
    nxt_stop  = stop_idx;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (Data_valid) begin
          accept    = 1'b1;
          nxt_state = START;
        end
      end
      START: begin
        if (bit_end) begin
          nxt_state = DATA;
          nxt_idx   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == LAST_IDX) begin
            nxt_state = par_en_l ? PARITY : STOP;
            nxt_stop  = 1'b0;
          end else begin
            nxt_idx = idx + IW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          nxt_state = STOP;
          nxt_stop  = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_idx == stop2_l) nxt_state = IDLE;
          else                     nxt_stop  = 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so each one lines up with its bit clock.
  always_comb begin
    case (nxt_state)
      START:   nxt_tx = 1'b0;
      DATA:    nxt_tx = data_l[nxt_idx];
      PARITY:  nxt_tx = (^data_l) ^ par_typ_l;
      default: nxt_tx = 1'b1;
    endcase
    nxt_done = (nxt_state == STOP) && (nxt_cnt == div_l) && (nxt_stop == stop2_l);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      stop_idx  <= 1'b0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      data_l    <= '0;
      par_en_l  <= 1'b0;
      par_typ_l <= 1'b0;
      stop2_l   <= 1'b0;
      div_l     <= '0;
    end else begin
      state    <= nxt_state;
      idx      <= nxt_idx;
      cnt      <= nxt_cnt;
      stop_idx <= nxt_stop;
      TX_OUT   <= nxt_tx;
      busy     <= (nxt_state != IDLE);
      tx_done  <= nxt_done;
      if (accept) begin
        data_l    <= P_DATA;
        par_en_l  <= par_en;
        par_typ_l <= par_typ;
        stop2_l   <= stop2;
        div_l     <= baud_div;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: 8-bit and 5-bit instances driven from a frame
// table, with per-clock expected line levels held in a scoreboard queue.
module tb_uart_tx_frame_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  pd8;
  logic [4:0]  pd5;
  logic        dv8, dv5, par_en, par_typ, stop2;
  logic [15:0] baud_div;
  logic        tx8, busy8, done8, tx5, busy5, done5;
  logic        sel5;

  int total = 0;
  int bad   = 0;
  logic q[$];

  typedef struct {
    logic        w5;
    logic        pe;
    logic        pt;
    logic        s2;
    logic [15:0] div;
    logic [8:0]  data;
    int          exp_len;
    logic        exp_par;
  } vec_t;

  vec_t vt[6];

  always #5 CLK = ~CLK;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut8 (
    .CLK(CLK), .RST(RST), .P_DATA(pd8), .Data_valid(dv8), .par_en(par_en),
    .par_typ(par_typ), .stop2(stop2), .baud_div(baud_div),
    .TX_OUT(tx8), .busy(busy8), .tx_done(done8)
  );

  uart_tx_frame_ctrl #(.DATA_WIDTH(5), .DIV_WIDTH(16)) dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(pd5), .Data_valid(dv5), .par_en(par_en),
    .par_typ(par_typ), .stop2(stop2), .baud_div(baud_div),
    .TX_OUT(tx5), .busy(busy5), .tx_done(done5)
  );

  function automatic logic [2:0] outs();
    return sel5 ? {tx5, busy5, done5} : {tx8, busy8, done8};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic idle_check(input int n, input string nm);
    repeat (n) begin
      @(negedge CLK);
      chk(nm, {26'd0, tx8, busy8, done8, tx5, busy5, done5}, 32'b100100);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first idle clock after the frame.
  task automatic run_frame(input vec_t v, input bit disturb);
    int bl;
    int busy_cnt;
    logic e;
    logic [2:0] o;
    sel5     = v.w5;
    par_en   = v.pe;
    par_typ  = v.pt;
    stop2    = v.s2;
    baud_div = v.div;
    pd8      = v.data[7:0];
    pd5      = v.data[4:0];
    if (v.w5) dv5 = 1'b1; else dv8 = 1'b1;
    bl = v.w5 ? 5 : 8;
    q.delete();
    for (int r = 0; r <= int'(v.div); r++) q.push_back(1'b0);
    for (int b = 0; b < bl; b++)
      for (int r = 0; r <= int'(v.div); r++) q.push_back(v.data[b]);
    if (v.pe)
      for (int r = 0; r <= int'(v.div); r++) q.push_back(v.exp_par);
    for (int s = 0; s < (v.s2 ? 2 : 1); s++)
      for (int r = 0; r <= int'(v.div); r++) q.push_back(1'b1);
    busy_cnt = 0;
    @(negedge CLK);
    if (!disturb) begin
      dv8 = 1'b0;
      dv5 = 1'b0;
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      o = outs();
      chk("tx_bit", {31'd0, o[2]}, {31'd0, e});
      chk("busy_in_frame", {31'd0, o[1]}, 32'd1);
      chk("tx_done", {31'd0, o[0]}, (q.size() == 0) ? 32'd1 : 32'd0);
      if (o[1]) busy_cnt++;
      if (disturb) begin
        if (v.w5) dv5 = 1'b1; else dv8 = 1'b1;
        pd8      = 8'h55;
        pd5      = 5'h15;
        par_typ  = ~par_typ;
        par_en   = ~par_en;
        stop2    = ~stop2;
        baud_div = 16'($urandom_range(0, 7));
      end
      @(negedge CLK);
    end
    o = outs();
    chk("idle_after_frame", {29'd0, o}, 32'b100);
    chk("busy_len", busy_cnt, v.exp_len);
    dv8 = 1'b0;
    dv5 = 1'b0;
  endtask

  initial begin
    pd8 = '0; pd5 = '0; dv8 = 0; dv5 = 0;
    par_en = 0; par_typ = 0; stop2 = 0; baud_div = '0; sel5 = 0;

    //         w5 pe pt s2 div    data      len par
    vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 9'h0A5, 11, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 9'h0A5, 11, 1'b1};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 9'h03C, 44, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 9'h013, 16, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 9'h096, 36, 1'b1};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 9'h00E, 8,  1'b0};

    #1 RST = 1'b0;
    #1 chk("reset_async", {26'd0, tx8, busy8, done8, tx5, busy5, done5}, 32'b100100);
    @(negedge CLK);
    chk("reset_held", {26'd0, tx8, busy8, done8, tx5, busy5, done5}, 32'b100100);
    RST = 1'b1;
    idle_check(2, "idle_post_reset");

    for (int i = 0; i < 6; i++) begin
      run_frame(vt[i], 1'b0);
      idle_check(2, "gap_idle");
    end

    // Inputs churn during the frame and Data_valid stays high through tx_done;
    // the next frame is picked up in the single idle clock that follows.
    run_frame(vt[0], 1'b1);
    run_frame(vt[2], 1'b0);
    idle_check(3, "after_chain");

    // Reset during data bit 4 of an 0xA5 frame.
    sel5 = 0; par_en = 1; par_typ = 0; stop2 = 0; baud_div = 16'd0; pd8 = 8'hA5;
    dv8 = 1'b1;
    @(negedge CLK);
    dv8 = 1'b0;
    repeat (5) @(negedge CLK);
    chk("pre_rst_bit4", {30'd0, tx8, busy8}, 32'b01);
    #2 RST = 1'b0;
    #1 chk("rst_mid_frame", {29'd0, tx8, busy8, done8}, 32'b100);
    @(negedge CLK);
    RST = 1'b1;
    idle_check(10, "post_rst_idle");
    run_frame(vt[1], 1'b0);
    idle_check(2, "final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
Parametrised UART transmit controller. It combines the frame FSM, serializer, parity generator and bit-period timer into one block.
- Data width, parity on/off and type, stop-bit count and baud divisor are all configurable.
- Sits between the system-side data source (valid pulse plus parallel word) and the TX pad.
- Next-generation replacement for the fixed 8-bit, one-stop, externally-ticked TX path.

Parameters:
DATA_WIDTH, 8, payload bits per frame (legal range 5..9)
DIV_WIDTH, 16, width of the baud_div input

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel payload, sampled on acceptance
Data_valid  input  1  request to send P_DATA; accepted only in IDLE
par_en  input  1  1 = parity bit present; latched on acceptance
par_typ  input  1  0 = even, 1 = odd; latched on acceptance
stop2  input  1  1 = two stop bits, 0 = one; latched on acceptance
baud_div  input  DIV_WIDTH  bit period = baud_div+1 clocks; latched on acceptance
TX_OUT  output  1  serial line, idle high
busy  output  1  high from the first start-bit clock through the last stop-bit clock
tx_done  output  1  one-clock pulse on the final clock of the last stop bit

Behaviour:
- Clock and reset: one clock (CLK); reset RST is asynchronous, active-low.
- Reset values: state=IDLE, TX_OUT=1, busy=0, tx_done=0, bit counter=0, period counter=0, and all latched config and data = 0.
- Registered outputs: all outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE to START:
  - On a CLK edge where state=IDLE and Data_valid=1, latch P_DATA, par_en, par_typ, stop2 and baud_div.
  - On that same edge: state<=START, TX_OUT<=0, busy<=1.
  - Latency from Data_valid sample to start bit on TX_OUT is one clock edge.
- Bit timing:
  - Each bit is held for exactly baud_div_latched+1 clocks; a period counter runs from 0 to baud_div_latched.
  - baud_div=0 gives one clock per bit.
- START: TX_OUT=0 for one bit period, then go to DATA with bit index 0.
- DATA:
  - TX_OUT = data_latched[idx], sent LSB first.
  - idx increments at each bit-period end.
  - After bit DATA_WIDTH-1, go to PARITY if par_en_latched, else to STOP.
- PARITY:
  - TX_OUT = XOR-reduce(data_latched) XOR par_typ_latched, for one bit period.
  - Even parity makes the total number of ones (data + parity) even.
- STOP:
  - TX_OUT=1 for one bit period, or two if stop2_latched.
  - tx_done=1 on the final clock of the last stop period.
  - Next edge: state<=IDLE, busy<=0, tx_done<=0.
- Frame length in clocks = (1 + DATA_WIDTH + par_en + 1 + stop2) × (baud_div+1).
- While busy:
  - Data_valid is ignored and no queuing occurs.
  - Changes to P_DATA or any config input do not affect the frame in flight.
- Back-to-back frames:
  - Data_valid high during the tx_done cycle is ignored.
  - Data_valid sampled in the following IDLE cycle is accepted, so the minimum inter-frame idle is one clock of TX_OUT=1.
- Reset asserted mid-frame: outputs go to reset values immediately (TX_OUT=1, busy=0) and the frame is abandoned. After release, the block waits in IDLE for a new Data_valid.
- Illegal state encodings recover to IDLE with TX_OUT=1.

Test Plan:
- DATA_WIDTH=8, baud_div=0, par_en=1, par_typ=0, stop2=0, P_DATA=0xA5, Data_valid one clock:
  - TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity=0, stop).
  - busy high 11 clocks; tx_done pulses on clock 11.
- Same as above with par_typ=1: parity bit = 1; all other bits identical.
- par_en=0, stop2=1, baud_div=3, P_DATA=0x3C:
  - Each bit is held 4 clocks; frame = 11 bits × 4 = 44 clocks busy.
  - Data bits 0,0,1,1,1,1,0,0, then 8 clocks of stop high.
- Mid-frame input changes:
  - Assert Data_valid with P_DATA=0x55 at clock 3 of a 0xA5 frame, and toggle par_typ and baud_div mid-frame.
  - Required: the 0xA5 frame is unchanged and 0x55 is never sent.
  - Data_valid re-asserted one clock after tx_done: second frame starts exactly one idle clock later.
- Reset mid-frame: drop RST during DATA bit 4 → TX_OUT=1, busy=0, tx_done=0 asynchronously. After release, no output until the next Data_valid.
- DATA_WIDTH=5 instance, baud_div=1, par_en=1 even, P_DATA=5'b10011:
  - Frame 0,1,1,0,0,1,1,1 (start, data, parity=1, stop), each bit 2 clocks.
  - Total 16 clocks busy.
